// File: rtl/mac_array_ctrl.sv
// rtl/mac_array_ctrl.sv - tile sequencer for the IC0 x OC0 weight-stationary MAC array
// Optional feature macro: MAC_ARRAY_CTRL_PERF_EN adds the stall_cnt output.
module mac_array_ctrl #(
  parameter int IC0   = 4,
  parameter int OC0   = 4,
  parameter int CNT_W = 16,
  parameter int LAT   = IC0 + OC0 - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_vec,
  output logic               busy,
  output logic               done,
  input  logic               weight_valid,
  output logic               weight_ready,
  input  logic               ifmap_valid,
  output logic               ifmap_ready,
  output logic               ofmap_valid,
  input  logic               ofmap_ready,
  output logic               en,
  output logic [IC0*OC0-1:0] en_weight
`ifdef MAC_ARRAY_CTRL_PERF_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int EW    = IC0 * OC0;
  localparam int ROW_W = (IC0 > 1) ? $clog2(IC0) : 1;
  localparam logic [EW-1:0] ROW_MASK = EW'({OC0{1'b1}});

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] nv_q, nv_d;
  // One bit per array pipeline stage; the top bit marks a finished result.
  logic [LAT-1:0]   vld_q, vld_d;

  logic             stall;
  logic             vec_acc;
  logic [LAT-1:0]   vld_body;

  // State and counter registers; reset abandons any tile in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      issued_q <= '0;
      nv_q     <= '0;
      vld_q    <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      issued_q <= issued_d;
      nv_q     <= nv_d;
      vld_q    <= vld_d;
    end
  end

  // Next-state logic and array/handshake controls for the current state.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    issued_d     = issued_q;
    nv_d         = nv_q;
    vld_d        = vld_q;
    busy         = (state_q != S_IDLE);
    done         = 1'b0;
    weight_ready = 1'b0;
    ifmap_ready  = 1'b0;
    en           = 1'b0;
    en_weight    = '0;
    ofmap_valid  = vld_q[LAT-1];
    // A finished result the consumer has not taken freezes the whole array.
    stall        = ofmap_valid & ~ofmap_ready;
    vec_acc      = 1'b0;
    vld_body     = vld_q;
    vld_body[LAT-1] = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          nv_d     = num_vec;
          row_d    = '0;
          issued_d = '0;
          vld_d    = '0;
          state_d  = (num_vec == '0) ? S_DONE : S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        weight_ready = 1'b1;
        if (weight_valid) begin
          en        = 1'b1;
          en_weight = ROW_MASK << (int'(row_q) * OC0);
          if (row_q == ROW_W'(IC0 - 1)) begin
            issued_d = '0;
            state_d  = S_COMPUTE;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      S_COMPUTE: begin
        en          = ~stall;
        ifmap_ready = ~stall & (issued_q < nv_q);
        vec_acc     = ifmap_valid & ifmap_ready;
        // Bubbles enter as zero so ofmap_valid only marks real vectors.
        if (en) vld_d = (vld_q << 1) | LAT'(vec_acc);
        if (vec_acc) begin
          issued_d = issued_q + CNT_W'(1);
          if (issued_d == nv_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        en = ~stall;
        if (en) vld_d = vld_q << 1;
        if ((vld_body == '0) && (~ofmap_valid | ofmap_ready)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef MAC_ARRAY_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;

  // Count array-phase cycles frozen by backpressure; saturates, cleared per tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      stall_cnt_q <= '0;
    end else if ((state_q == S_COMPUTE || state_q == S_DRAIN) && !en &&
                 (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// tb/tb_mac_array_ctrl.sv - self-checking bench for mac_array_ctrl
module tb_mac_array_ctrl;

  localparam int IC0   = 4;
  localparam int OC0   = 4;
  localparam int CNT_W = 16;
  localparam int LAT   = IC0 + OC0 - 1;
  localparam int EW    = IC0 * OC0;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vec = '0;
  logic             weight_valid = 1'b0;
  logic             ifmap_valid = 1'b0;
  logic             ofmap_ready = 1'b1;
  logic             busy, done, weight_ready, ifmap_ready, ofmap_valid, en;
  logic [EW-1:0]    en_weight;
`ifdef MAC_ARRAY_CTRL_PERF_EN
  logic [31:0]      stall_cnt;
  logic [31:0]      sc_at_done, sc_off1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mac_array_ctrl #(.IC0(IC0), .OC0(OC0), .CNT_W(CNT_W), .LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_vec      (num_vec),
    .busy         (busy),
    .done         (done),
    .weight_valid (weight_valid),
    .weight_ready (weight_ready),
    .ifmap_valid  (ifmap_valid),
    .ifmap_ready  (ifmap_ready),
    .ofmap_valid  (ofmap_valid),
    .ofmap_ready  (ofmap_ready),
    .en           (en),
    .en_weight    (en_weight)
`ifdef MAC_ARRAY_CTRL_PERF_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  // Reference model: weights loaded, vectors issued, a queue of in-flight
  // vectors stamped with the enable count at issue; a vector emerges once
  // LAT enabled cycles have passed since its issue.
  bit  m_busy, m_done;
  int  m_nv, m_wl, m_iss, m_enc, m_stall;
  int  m_q[$];
  logic e_busy, e_done, e_wr, e_ir, e_ov, e_en;
  logic [EW-1:0] e_ew;

  // Per-tile observation records (offset 0 = start cycle).
  int   t_off, done_at, n_cons, guard;
  logic ov_hist [64];
  logic en_hist [64];
  logic [EW-1:0] ew_hist [64];
  logic s_busy, s_done, s_en, s_ir, s_wr, s_ov;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] row_bits(input int r);
    logic [EW-1:0] v;
    v = '0;
    for (int j = 0; j < OC0; j++) v[r*OC0 + j] = 1'b1;
    return v;
  endfunction

  function automatic bit head_ready();
    if (!m_busy || m_done || m_wl < IC0 || m_q.size() == 0) return 1'b0;
    return (m_q[0] + LAT - 1 == m_enc);
  endfunction

  task automatic model_eval();
    e_busy = m_busy; e_done = 1'b0; e_wr = 1'b0; e_ir = 1'b0;
    e_ov = 1'b0; e_en = 1'b0; e_ew = '0;
    if (m_busy) begin
      if (m_done) begin
        e_done = 1'b1;
      end else if (m_wl < IC0) begin
        e_wr = 1'b1;
        if (weight_valid) begin
          e_en = 1'b1;
          e_ew = row_bits(m_wl);
        end
      end else begin
        e_ov = head_ready();
        e_en = !(e_ov && !ofmap_ready);
        e_ir = e_en && (m_iss < m_nv);
      end
    end
  endtask

  task automatic model_step();
    bit draining;
    if (rst) begin
      m_busy = 0; m_done = 0; m_stall = 0; m_q.delete();
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_nv = int'(num_vec); m_wl = 0; m_iss = 0; m_enc = 0;
        m_stall = 0; m_q.delete(); m_done = (num_vec == '0);
      end
    end else if (m_done) begin
      m_busy = 0; m_done = 0;
    end else if (m_wl < IC0) begin
      if (weight_valid) m_wl++;
    end else begin
      draining = (m_iss == m_nv);
      if (!e_en) m_stall++;
      if (e_en) m_enc++;
      if (e_ir && ifmap_valid) begin
        m_iss++;
        m_q.push_back(m_enc);
      end
      if (e_ov && ofmap_ready) void'(m_q.pop_front());
      if (draining && m_q.size() == 0) m_done = 1;
    end
  endtask

  // One clock: inputs already driven; sample at the falling edge, then advance.
  task automatic tick();
    #4;
    model_eval();
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("weight_ready", 64'(weight_ready), 64'(e_wr));
    chk("ifmap_ready", 64'(ifmap_ready), 64'(e_ir));
    chk("ofmap_valid", 64'(ofmap_valid), 64'(e_ov));
    chk("en", 64'(en), 64'(e_en));
    chk("en_weight", 64'(en_weight), 64'(e_ew));
`ifdef MAC_ARRAY_CTRL_PERF_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    if (done === 1'b1) sc_at_done = stall_cnt;
    if (t_off == 1) sc_off1 = stall_cnt;
`endif
    s_busy = busy; s_done = done; s_en = en; s_ir = ifmap_ready;
    s_wr = weight_ready; s_ov = ofmap_valid;
    if (t_off < 64) begin
      ov_hist[t_off] = ofmap_valid;
      en_hist[t_off] = en;
      ew_hist[t_off] = en_weight;
    end
    if (done === 1'b1 && done_at < 0) done_at = t_off;
    if (ofmap_valid === 1'b1 && ofmap_ready === 1'b1) n_cons++;
    t_off++;
    model_step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: all valid; 1: weight gap + ifmap 1,0,1; 2: 5-cycle backpressure;
  // 3: random valids/ready; 4: start held high while busy with another num_vec.
  task automatic run_tile(input int nv, input int mode);
    int k, bp_left, gap_left;
    for (int i = 0; i < 64; i++) begin
      ov_hist[i] = 1'b0; en_hist[i] = 1'b0; ew_hist[i] = '0;
    end
    t_off = 0; done_at = -1; n_cons = 0; guard = 0;
    k = 0; bp_left = 5; gap_left = 2;
    start = 1'b1; num_vec = CNT_W'(nv);
    weight_valid = 1'b1; ifmap_valid = 1'b1; ofmap_ready = 1'b1;
    tick();
    start = 1'b0;
    while (done_at < 0 && guard < 2000) begin
      weight_valid = 1'b1; ifmap_valid = 1'b1; ofmap_ready = 1'b1;
      case (mode)
        1: begin
          if (m_busy && !m_done && m_wl == 2 && gap_left > 0) begin
            weight_valid = 1'b0;
            gap_left--;
          end
          if (m_busy && !m_done && m_wl == IC0 && m_iss < m_nv) begin
            ifmap_valid = (k != 1);
            k++;
          end
        end
        2: begin
          if (head_ready() && bp_left > 0) begin
            ofmap_ready = 1'b0;
            bp_left--;
          end
        end
        3: begin
          weight_valid = ($urandom_range(0, 3) != 0);
          ifmap_valid  = ($urandom_range(0, 2) != 0);
          ofmap_ready  = ($urandom_range(0, 3) != 0);
        end
        4: begin
          start   = 1'b1;
          num_vec = CNT_W'(9);
        end
        default: ;
      endcase
      tick();
      guard++;
    end
    start = 1'b0;
    chk("tile_finished", 64'(done_at >= 0), 64'(1));
  endtask

  initial begin
    @(posedge clk);
    #1;
    tick();
    tick();
    chk("reset_busy", 64'(s_busy), 64'(0));
    chk("reset_en", 64'(s_en), 64'(0));
    rst = 1'b0;
    tick();

    // Basic tile: 4 weight rows, 3 vectors, results LAT cycles after issue.
    run_tile(3, 0);
    chk("basic_done_at", 64'(done_at), 64'(15));
    chk("basic_results", 64'(n_cons), 64'(3));
    chk("basic_ew_row0", 64'(ew_hist[1]), 64'h000F);
    chk("basic_ew_row1", 64'(ew_hist[2]), 64'h00F0);
    chk("basic_ew_row2", 64'(ew_hist[3]), 64'h0F00);
    chk("basic_ew_row3", 64'(ew_hist[4]), 64'hF000);
    chk("basic_ov_pre", 64'(ov_hist[11]), 64'(0));
    chk("basic_ov_pattern", 64'({ov_hist[12], ov_hist[13], ov_hist[14]}), 64'b111);

    // Gaps in the weight and ifmap streams.
    run_tile(2, 1);
    chk("gap_en", 64'({en_hist[3], en_hist[4]}), 64'(0));
    chk("gap_ew", 64'(ew_hist[3] | ew_hist[4]), 64'(0));
    chk("gap_ew_row2", 64'(ew_hist[5]), 64'h0F00);
    chk("gap_ov_pattern", 64'({ov_hist[14], ov_hist[15], ov_hist[16]}), 64'b101);
    chk("gap_done_at", 64'(done_at), 64'(17));

    // Backpressure on the first result for 5 cycles.
    run_tile(3, 2);
    chk("bp_en_held", 64'({en_hist[12], en_hist[13], en_hist[14], en_hist[15], en_hist[16]}), 64'(0));
    chk("bp_ov_held", 64'({ov_hist[12], ov_hist[13], ov_hist[14], ov_hist[15], ov_hist[16]}), 64'b11111);
    chk("bp_results", 64'(n_cons), 64'(3));
    chk("bp_done_at", 64'(done_at), 64'(20));
`ifdef MAC_ARRAY_CTRL_PERF_EN
    chk("perf_at_done", 64'(sc_at_done), 64'(5));
`endif

    // Empty tile: done the cycle after start, no array activity.
    run_tile(0, 0);
    chk("nv0_done_at", 64'(done_at), 64'(1));
    chk("nv0_en", 64'({en_hist[0], en_hist[1]}), 64'(0));
    chk("nv0_ew", 64'(ew_hist[0] | ew_hist[1]), 64'(0));
`ifdef MAC_ARRAY_CTRL_PERF_EN
    chk("perf_cleared", 64'(sc_off1), 64'(0));
`endif

    // start while busy must not relatch num_vec.
    run_tile(2, 4);
    chk("busy_start_results", 64'(n_cons), 64'(2));
    chk("busy_start_done_at", 64'(done_at), 64'(14));

    // Random tiles.
    for (int n = 0; n < 6; n++) begin
      int nv;
      nv = $urandom_range(1, 12);
      run_tile(nv, 3);
      chk("rand_results", 64'(n_cons), 64'(nv));
    end

    // Reset in the middle of COMPUTE.
    t_off = 0; done_at = -1; n_cons = 0; guard = 0;
    start = 1'b1; num_vec = CNT_W'(5);
    weight_valid = 1'b1; ifmap_valid = 1'b1; ofmap_ready = 1'b1;
    tick();
    start = 1'b0;
    while (!(m_wl == IC0 && m_iss >= 2) && guard < 100) begin
      tick();
      guard++;
    end
    chk("rst_mid_reached", 64'(s_busy), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_mid_busy", 64'(s_busy), 64'(0));
    chk("rst_mid_done", 64'(s_done), 64'(0));
    chk("rst_mid_en", 64'(s_en), 64'(0));
    chk("rst_mid_ir", 64'(s_ir), 64'(0));
    chk("rst_mid_wr", 64'(s_wr), 64'(0));
    chk("rst_mid_ov", 64'(s_ov), 64'(0));
    for (int n = 0; n < 10; n++) tick();
    chk("rst_mid_no_done", 64'(done_at), 64'(-1));

    run_tile(4, 3);
    chk("post_rst_results", 64'(n_cons), 64'(4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
